// File: rtl/multi_cycle_controller_pkg.sv
// rtl/multi_cycle_controller_pkg.sv - shared encodings for the multi-cycle RV32I controller
package multi_cycle_controller_pkg;

    // Opcodes recognised by the decoder
    localparam logic [6:0] R_T    = 7'b0110011;
    localparam logic [6:0] I_T    = 7'b0010011;
    localparam logic [6:0] LW_T   = 7'b0000011;
    localparam logic [6:0] S_T    = 7'b0100011;
    localparam logic [6:0] B_T    = 7'b1100011;
    localparam logic [6:0] J_T    = 7'b1101111;
    localparam logic [6:0] JALR_T = 7'b1100111;
    localparam logic [6:0] U_T    = 7'b0110111;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result and ALU operand selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    // FSM state encoding
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_JALR     = 4'd11;
    localparam state_t S_JALWB    = 4'd12;
    localparam state_t S_LUI      = 4'd13;
    localparam state_t S_ERROR    = 4'd14;

    // Branch condition from ALU flags; unsigned compares are not supported and never taken
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero, input logic lt);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return ~zero;
            3'b100:  return lt;
            3'b101:  return ~lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// rtl/multi_cycle_controller_alu_decoder.sv - ALU operation select from opcode/funct fields
module alu_decoder
    import multi_cycle_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [2:0] alu_control
);

    // Only funct7[5] distinguishes SUB from ADD; the rest is immediate or reserved
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Branches compare by subtraction (eq/ne) or set-less-than (lt/ge); ALU ops by funct3
    always_comb begin
        alu_control = ALU_ADD;
        if (op == B_T) begin
            alu_control = funct3[2] ? ALU_SLT : ALU_SUB;
        end else if (op == R_T || op == I_T) begin
            case (funct3)
                3'b000:  alu_control = (op == R_T && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_control = ALU_SLT;
                3'b100:  alu_control = ALU_XOR;
                3'b110:  alu_control = ALU_OR;
                3'b111:  alu_control = ALU_AND;
                default: alu_control = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - main FSM sequencer of the multi-cycle RV32I core
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
#(
    parameter logic MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       ALUlt,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t     state;
    state_t     state_next;
    logic       ready;
    logic [2:0] dec_alu;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign State = state;

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu)
    );

    // State register; reset returns to FETCH immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Next state and per-state datapath controls; everything forced low while rst is high
    always_comb begin
        state_next = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                case (op)
                    LW_T, S_T: state_next = S_MEMADR;
                    R_T:       state_next = S_EXECR;
                    I_T:       state_next = S_EXECI;
                    B_T:       state_next = S_BRANCH;
                    J_T:       state_next = S_JAL;
                    JALR_T:    state_next = S_JALR;
                    U_T:       state_next = S_LUI;
                    default:   state_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                if (op == S_T) begin
                    ImmSrc     = IMM_S;
                    state_next = S_MEMWRITE;
                end else begin
                    ImmSrc     = IMM_I;
                    state_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUControl = dec_alu;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUControl = dec_alu;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ResultSrc  = RES_ALUOUT;
                ALUControl = dec_alu;
                PCWrite    = branch_taken(funct3, Zero, ALUlt);
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ResultSrc  = RES_ALURESULT;
                PCWrite    = 1'b1;
                state_next = S_JALWB;
            end
            S_JALWB: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_LUI: begin
                ImmSrc     = IMM_U;
                ResultSrc  = RES_IMM;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_ERROR: begin
                Illegal = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
        if (rst) begin
            state_next = S_FETCH;
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ImmSrc     = 3'b000;
            ALUControl = 3'b000;
            Illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - scoreboard bench for multi_cycle_controller
module tb_multi_cycle_controller;
    import multi_cycle_controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       Zero = 1'b0;
    logic       ALUlt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc, ALUControl;
    logic [3:0] State;

    multi_cycle_controller #(.MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .ALUlt(ALUlt), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
        .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, adr, mr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu;
    } obs_t;

    typedef struct {
        obs_t  val;
        obs_t  care;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    string cur = "reset";
    obs_t  obs;

    assign obs = {State, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Illegal,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle on the falling edge
    always @(negedge clk) begin
        exp_t e;
        chk("mem_exclusive", {31'b0, MemRead & MemWrite}, 32'd0);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (((obs ^ e.val) & e.care) !== 23'b0) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (mask %h)", e.tag, obs, e.val, e.care);
            end
        end
    end

    // Expectation for a state: strobes, Illegal and ALUControl always checked, selects on request
    function automatic exp_t ex(logic [3:0] st, string phase);
        exp_t e;
        e.val  = '0;
        e.care = '0;
        e.val.st = st;
        e.care.st = '1;
        e.care.pcw = 1'b1; e.care.mr = 1'b1; e.care.mw = 1'b1;
        e.care.irw = 1'b1; e.care.rw = 1'b1; e.care.ill = 1'b1;
        e.care.alu = '1;
        e.tag = {cur, ":", phase};
        return e;
    endfunction

    function automatic exp_t with_sel(exp_t ein, int a, int b, int rs, int imm);
        exp_t e = ein;
        if (a >= 0)   begin e.val.sa  = a[1:0];   e.care.sa  = '1; end
        if (b >= 0)   begin e.val.sb  = b[1:0];   e.care.sb  = '1; end
        if (rs >= 0)  begin e.val.rs  = rs[1:0];  e.care.rs  = '1; end
        if (imm >= 0) begin e.val.imm = imm[2:0]; e.care.imm = '1; end
        return e;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e.val  = '0;
        e.care = '1;
        e.tag  = {cur, ":in_reset"};
        return e;
    endfunction

    // Reference ALU selection from RV32I instruction semantics
    function automatic logic [2:0] alu_ref(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        if (o == 7'b1100011) return (f3 == 3'b100 || f3 == 3'b101) ? 3'b101 : 3'b001;
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_legal(logic [6:0] o);
        return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    endfunction

    task automatic step_raw(exp_t e, logic rdy, logic z, logic l, logic r);
        rst = r; mem_ready = rdy; Zero = z; ALUlt = l;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic step(exp_t e, logic rdy);
        step_raw(e, rdy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++)
            step_raw(rst_exp(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic do_fetch(int wf);
        exp_t e;
        e = with_sel(ex(S_FETCH, "fetch"), 0, 2, 2, -1);
        e.val.mr = 1'b1; e.care.adr = 1'b1;
        for (int i = 0; i < wf; i++) step(e, 1'b0);
        e.val.irw = 1'b1; e.val.pcw = 1'b1;
        step(e, 1'b1);
        step(with_sel(ex(S_DECODE, "decode"), 1, 1, -1, 2), 1'($urandom_range(0, 1)));
    endtask

    task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                             int wf, int wm, int a, int b);
        exp_t e;
        bit   taken;
        cur = name; op = o; funct3 = f3; funct7 = f7;
        do_fetch(wf);
        case (o)
            7'b0000011, 7'b0100011: begin
                step(with_sel(ex(S_MEMADR, "memadr"), 2, 1, -1, (o == 7'b0100011) ? 1 : 0),
                     1'($urandom_range(0, 1)));
                e = ex((o == 7'b0100011) ? S_MEMWRITE : S_MEMREAD, "mem");
                e.val.adr = 1'b1; e.care.adr = 1'b1;
                if (o == 7'b0100011) e.val.mw = 1'b1; else e.val.mr = 1'b1;
                for (int i = 0; i < wm; i++) step(e, 1'b0);
                step(e, 1'b1);
                if (o == 7'b0000011) begin
                    e = with_sel(ex(S_MEMWB, "memwb"), -1, -1, 1, -1);
                    e.val.rw = 1'b1;
                    step(e, 1'($urandom_range(0, 1)));
                end
            end
            7'b0110011, 7'b0010011: begin
                e = with_sel(ex((o == 7'b0110011) ? S_EXECR : S_EXECI, "exec"), 2,
                             (o == 7'b0110011) ? 0 : 1, -1, (o == 7'b0110011) ? -1 : 0);
                e.val.alu = alu_ref(o, f3, f7);
                step(e, 1'($urandom_range(0, 1)));
                e = with_sel(ex(S_ALUWB, "aluwb"), -1, -1, 0, -1);
                e.val.rw = 1'b1;
                step(e, 1'($urandom_range(0, 1)));
            end
            7'b1100011: begin
                case (f3)
                    3'b000:  taken = (a == b);
                    3'b001:  taken = (a != b);
                    3'b100:  taken = (a < b);
                    3'b101:  taken = (a >= b);
                    default: taken = 1'b0;
                endcase
                e = with_sel(ex(S_BRANCH, "branch"), 2, 0, 0, -1);
                e.val.pcw = taken;
                e.val.alu = alu_ref(o, f3, f7);
                if (!(f3 inside {3'b000, 3'b001, 3'b100, 3'b101})) e.care.alu = '0;
                step_raw(e, 1'($urandom_range(0, 1)), a == b, a < b, 1'b0);
            end
            7'b1101111: begin
                e = with_sel(ex(S_JAL, "jal"), 1, 2, 0, -1);
                e.val.pcw = 1'b1;
                step(e, 1'($urandom_range(0, 1)));
                e = with_sel(ex(S_ALUWB, "aluwb"), -1, -1, 0, -1);
                e.val.rw = 1'b1;
                step(e, 1'($urandom_range(0, 1)));
            end
            7'b1100111: begin
                e = with_sel(ex(S_JALR, "jalr"), 2, 1, 2, 0);
                e.val.pcw = 1'b1;
                step(e, 1'($urandom_range(0, 1)));
                e = with_sel(ex(S_JALWB, "jalwb"), 1, 2, 2, -1);
                e.val.rw = 1'b1;
                step(e, 1'($urandom_range(0, 1)));
            end
            7'b0110111: begin
                e = with_sel(ex(S_LUI, "lui"), -1, -1, 3, 4);
                e.val.rw = 1'b1;
                step(e, 1'($urandom_range(0, 1)));
            end
            default: begin
                e = ex(S_ERROR, "error");
                e.val.ill = 1'b1;
                for (int i = 0; i < 20; i++) step(e, 1'($urandom_range(0, 1)));
                do_reset(2);
            end
        endcase
    endtask

    initial begin
        exp_t  e;
        logic [6:0] o;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [2:0] alu_f3[5]  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
        logic [2:0] br_f3[6]   = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [6:0] kinds[9]   = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0110011, 7'b0010011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};

        @(posedge clk); #1;
        do_reset(3);

        run_instr("add",       7'b0110011, 3'b000, 7'h00, 0, 0, 0, 0);
        run_instr("lw_wait2",  7'b0000011, 3'b010, 7'h00, 0, 2, 0, 0);
        run_instr("bne_taken", 7'b1100011, 3'b001, 7'h00, 0, 0, 1, 2);
        run_instr("bne_not",   7'b1100011, 3'b001, 7'h00, 0, 0, 2, 2);
        run_instr("blt_taken", 7'b1100011, 3'b100, 7'h00, 0, 0, -1, 1);
        run_instr("sub",       7'b0110011, 3'b000, 7'h20, 1, 0, 0, 0);
        run_instr("addi_f7",   7'b0010011, 3'b000, 7'h20, 0, 0, 0, 0);
        run_instr("illegal",   7'b1111111, 3'b000, 7'h00, 0, 0, 0, 0);

        // Reset asserted while a store is waiting on memory
        cur = "sw_abort"; op = 7'b0100011; funct3 = 3'b010; funct7 = 7'h00;
        do_fetch(0);
        step(with_sel(ex(S_MEMADR, "memadr"), 2, 1, -1, 1), 1'b0);
        e = ex(S_MEMWRITE, "memwrite_hold");
        e.val.mw = 1'b1; e.val.adr = 1'b1; e.care.adr = 1'b1;
        step(e, 1'b0);
        mem_ready = 1'b0;
        #2;
        chk("sw_abort_before_rst", {31'b0, MemWrite}, 32'd1);
        rst = 1'b1;
        #1;
        chk("sw_abort_memwrite_drop", {31'b0, MemWrite}, 32'd0);
        chk("sw_abort_state", {28'b0, State}, {28'b0, S_FETCH});
        @(posedge clk); #1;
        do_reset(2);
        run_instr("after_abort_lui", 7'b0110111, 3'b000, 7'h00, 0, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            o  = kinds[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            if (o == 7'b0110011) begin
                f3 = alu_f3[$urandom_range(0, 4)];
                f7 = (f3 == 3'b000 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end else if (o == 7'b0010011) begin
                f3 = alu_f3[$urandom_range(0, 4)];
            end else if (o == 7'b1100011) begin
                f3 = br_f3[$urandom_range(0, 5)];
            end
            if ($urandom_range(0, 29) == 0) begin
                do o = 7'($urandom); while (is_legal(o));
            end
            run_instr($sformatf("rnd%0d_op%0h", n, o), o, f3, f7, $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 4) - 2, $urandom_range(0, 4) - 2);
        end

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
